// File: rtl/capture_dump_ctrl.sv
// capture_dump_ctrl: key debounce, I2S capture gating and framed
// L/R FIFO dump to a UART byte interface for the two-mic capture path.

module capture_dump_key_deb #(
    parameter int DEB_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // Synchronise the raw key, accept a new level after DEB_CYC stable
    // cycles and pulse on the accepted falling transition only
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != level) begin
                if (cnt == CW'(DEB_CYC - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                    press <= level;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

module capture_dump_ctrl #(
    parameter int         DW      = 16,
    parameter int         DEB_CYC = 1000,
    parameter logic [7:0] HDR0    = 8'hA5,
    parameter logic [7:0] HDR1    = 8'h5A
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_cap_n,
    input  logic          key_dump_n,
    input  logic          ws,
    output logic          cap_en,
    input  logic          fifo_l_full,
    input  logic          fifo_r_full,
    input  logic          fifo_l_empty,
    input  logic          fifo_r_empty,
    output logic          fifo_l_rd_en,
    output logic          fifo_r_rd_en,
    input  logic [DW-1:0] fifo_l_dout,
    input  logic [DW-1:0] fifo_r_dout,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic [2:0]    state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        CAPTURE = 3'd2,
        FULL    = 3'd3,
        DUMP    = 3'd4
    } state_t;

    // Dump sub-sequence: headers, per-channel read decision,
    // data latch, then the two bytes of the latched sample
    typedef enum logic [2:0] {
        D_H0  = 3'd0,
        D_H1  = 3'd1,
        D_PL  = 3'd2,
        D_PR  = 3'd3,
        D_LAT = 3'd4,
        D_HI  = 3'd5,
        D_LO  = 3'd6
    } dstate_t;

    state_t        state;
    state_t        state_n;
    dstate_t       dstate;
    dstate_t       dstate_n;
    logic          cap_press;
    logic          dump_press;
    logic          ws_q;
    logic          ws_fall;
    logic          chan;
    logic [DW-1:0] samp;
    logic          both_empty;
    logic          any_full;
    logic          tx_done;

    capture_dump_key_deb #(
        .DEB_CYC(DEB_CYC)
    ) u_deb_cap (
        .clk  (clk),
        .rst  (rst),
        .key_n(key_cap_n),
        .press(cap_press)
    );

    capture_dump_key_deb #(
        .DEB_CYC(DEB_CYC)
    ) u_deb_dump (
        .clk  (clk),
        .rst  (rst),
        .key_n(key_dump_n),
        .press(dump_press)
    );

    assign ws_fall    = ws_q & ~ws;
    assign both_empty = fifo_l_empty & fifo_r_empty;
    assign any_full   = fifo_l_full | fifo_r_full;
    assign tx_done    = tx_valid & tx_ready;

    // State registers for the top-level and dump sequencers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            dstate <= D_H0;
        end else begin
            state  <= state_n;
            dstate <= dstate_n;
        end
    end

    // Word-select history for 1->0 edge detection while armed
    always_ff @(posedge clk) begin
        if (rst) begin
            ws_q <= 1'b0;
        end else begin
            ws_q <= ws;
        end
    end

    // Remember which channel was read and latch its data one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            chan <= 1'b0;
            samp <= '0;
        end else begin
            if (fifo_r_rd_en) begin
                chan <= 1'b1;
            end else if (fifo_l_rd_en) begin
                chan <= 1'b0;
            end
            if (state == DUMP && dstate == D_LAT) begin
                samp <= chan ? fifo_r_dout : fifo_l_dout;
            end
        end
    end

    // Next-state logic; byte states advance only on a completed transfer
    always_comb begin
        state_n  = state;
        dstate_n = dstate;
        unique case (state)
            IDLE: begin
                if (cap_press) begin
                    state_n = ARM;
                end else if (dump_press && !both_empty) begin
                    state_n  = DUMP;
                    dstate_n = D_H0;
                end
            end
            ARM: begin
                if (ws_fall) begin
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                if (any_full) begin
                    state_n = FULL;
                end
            end
            FULL: begin
                if (dump_press) begin
                    state_n  = DUMP;
                    dstate_n = D_H0;
                end
            end
            DUMP: begin
                unique case (dstate)
                    D_H0: begin
                        if (tx_done) begin
                            dstate_n = D_H1;
                        end
                    end
                    D_H1: begin
                        if (tx_done) begin
                            dstate_n = D_PL;
                        end
                    end
                    D_PL: begin
                        if (!fifo_l_empty || !fifo_r_empty) begin
                            dstate_n = D_LAT;
                        end else begin
                            state_n  = IDLE;
                            dstate_n = D_H0;
                        end
                    end
                    D_PR: begin
                        dstate_n = fifo_r_empty ? D_PL : D_LAT;
                    end
                    D_LAT: begin
                        dstate_n = D_HI;
                    end
                    D_HI: begin
                        if (tx_done) begin
                            dstate_n = D_LO;
                        end
                    end
                    D_LO: begin
                        if (tx_done) begin
                            dstate_n = chan ? D_PL : D_PR;
                        end
                    end
                    default: begin
                        dstate_n = D_H0;
                    end
                endcase
            end
            default: begin
                state_n  = IDLE;
                dstate_n = D_H0;
            end
        endcase
    end

    // Outputs decoded from state; read strobes only in decision states
    always_comb begin
        cap_en       = (state == CAPTURE);
        busy         = (state != IDLE);
        state_dbg    = state;
        fifo_l_rd_en = 1'b0;
        fifo_r_rd_en = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        if (state == DUMP) begin
            unique case (dstate)
                D_H0: begin
                    tx_valid = 1'b1;
                    tx_data  = HDR0;
                end
                D_H1: begin
                    tx_valid = 1'b1;
                    tx_data  = HDR1;
                end
                D_PL: begin
                    fifo_l_rd_en = ~fifo_l_empty;
                    fifo_r_rd_en = fifo_l_empty & ~fifo_r_empty;
                end
                D_PR: begin
                    fifo_r_rd_en = ~fifo_r_empty;
                end
                D_HI: begin
                    tx_valid = 1'b1;
                    tx_data  = samp[15:8];
                end
                D_LO: begin
                    tx_valid = 1'b1;
                    tx_data  = samp[7:0];
                end
                default: begin
                    tx_valid = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/capture_dump_ctrl.md
Name: capture_dump_ctrl

Overview:
Sequencer for the two-mic capture path. It debounces the capture and dump keys, gates the I2S capture on word-select boundaries until either channel FIFO fills, then drains both FIFOs to the UART transmitter. Samples go out as a framed, interleaved byte stream. It sits in mic_subsys between the key pads, the I2S capture enables, the L/R FIFO read ports and the UART TX byte interface.

Parameters:
DW, 16, sample width of FIFO read data (must be 16; two bytes per sample)
DEB_CYC, 1000, consecutive stable clk cycles required to accept a key level
HDR0, 8'hA5, first header byte of a dump frame
HDR1, 8'h5A, second header byte of a dump frame

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
key_cap_n  input  1  raw capture key, active low, asynchronous to clk
key_dump_n  input  1  raw dump key, active low, asynchronous to clk
ws  input  1  I2S word select from capture block (clk-synchronous)
cap_en  output  1  enables I2S capture writes into both FIFOs
fifo_l_full  input  1  left FIFO full
fifo_r_full  input  1  right FIFO full
fifo_l_empty  input  1  left FIFO empty
fifo_r_empty  input  1  right FIFO empty
fifo_l_rd_en  output  1  left FIFO read strobe, one-cycle pulse
fifo_r_rd_en  output  1  right FIFO read strobe, one-cycle pulse
fifo_l_dout  input  DW  left read data, valid the cycle after rd_en
fifo_r_dout  input  DW  right read data, valid the cycle after rd_en
tx_data  output  8  byte to UART TX
tx_valid  output  1  tx_data valid; held until accepted
tx_ready  input  1  UART TX can accept a byte
busy  output  1  high in any state except IDLE
state_dbg  output  3  current top-level state encoding

Behaviour:
- Reset: all outputs 0; state IDLE; debounce counters 0; both debounced key levels released (high).
- Key path: 2-FF synchroniser per key. The filtered level changes only after DEB_CYC consecutive cycles of the new synchronised level. The falling edge of the filtered level produces a one-cycle press pulse. A key held low gives exactly one pulse.
- State encoding: IDLE=0, ARM=1, CAPTURE=2, FULL=3, DUMP=4.
- IDLE:
  - cap press -> ARM.
  - dump press with either FIFO non-empty -> DUMP.
  - dump press with both FIFOs empty is ignored.
  - Simultaneous cap and dump press: cap wins.
- ARM: wait for a ws falling edge (ws registered, detect 1->0). cap_en rises on the cycle after the edge is detected -> CAPTURE.
- CAPTURE:
  - cap_en=1.
  - When fifo_l_full or fifo_r_full is sampled high, cap_en=0 on the next cycle -> FULL.
  - Key presses are ignored.
- FULL: cap_en=0. dump press -> DUMP. cap press is ignored.
- DUMP sub-sequence:
  - Send HDR0, then HDR1.
  - Then loop per pair: left sample (if !fifo_l_empty), then right sample (if !fifo_r_empty).
  - Per sample: rd_en pulse for 1 cycle; next cycle latch dout; send dout[15:8], then dout[7:0].
  - An empty channel is skipped, with no rd_en and no bytes.
  - When both empties are high at the start of a pair -> IDLE. No trailer byte.
- Byte handshake:
  - A byte transfers on a clk edge with tx_valid && tx_ready.
  - tx_data is stable while tx_valid=1.
  - The next byte may be presented the cycle after transfer.
  - tx_valid is never high while rd_en is pulsing.
- Ordering: rd_en is never issued to a FIFO whose empty is high in that cycle. Exactly one rd_en is issued per transmitted sample.
- busy=1 whenever state != IDLE.
- Reset asserted mid-operation returns every output to its reset value at the next clk edge, including mid-byte with tx_valid high. The byte is abandoned and FIFO contents are not touched.
- Minimum dump cost: 2 header bytes, plus 2 bytes per non-empty sample.

Test Plan:
- Reset + debounce: DEB_CYC=4; key_cap_n low for 3 cycles then high -> no ARM. Low for 10 cycles -> exactly one press pulse; state 0 -> 1.
- Capture gating: in ARM, ws toggles every 32 clk -> cap_en rises exactly 1 cycle after the first ws 1->0 edge. Assert fifo_l_full -> cap_en=0 the next cycle, state_dbg=3.
- Dump stream: FIFOs each hold 2 samples (L=16'h1234,16'h5678; R=16'hABCD,16'hEF01), tx_ready=1 -> tx bytes A5 5A 12 34 AB CD 56 78 EF 01, then IDLE with busy=0.
- Backpressure: same data, tx_ready toggles every 3 cycles -> identical byte sequence; tx_data is constant while tx_valid && !tx_ready; no rd_en occurs while tx_valid=1.
- Unbalanced/ignored keys:
  - L holds 1 sample (16'h00FF), R is empty -> bytes A5 5A 00 FF with no fifo_r_rd_en.
  - A cap press during DUMP or CAPTURE leaves the state unchanged.
  - A dump press in IDLE with both FIFOs empty keeps state 0.
- Reset mid-dump: assert rst while tx_valid=1 after the 3rd byte -> next edge tx_valid=0, cap_en=0, state_dbg=0, busy=0.
